puf_eval_sequencer: RTL
=======================

Name: puf_eval_sequencer

Overview:
- Sequences one arbiter/ring-oscillator PUF evaluation for each challenge.
- Detects a new challenge or a user button press, clears the RO counters via a clr/clr_done handshake, and waits for the oscillators to settle.
- Enables the oscillators for a fixed count window, then compares the two counts and emits a 1-bit response with a valid pulse.
- Sits between the top-level switches/button and the RO counter pair plus challenge mux.

Parameters:
- CHAL_W, 8, challenge width.
- CNT_W, 16, RO counter width.
- SETTLE_CYC, 4, cycles between clear done and oscillator enable.
- WINDOW_CYC, 1000, cycles ro_en is held high.
- CLR_TMO, 255, maximum cycles to wait for clr_done before flagging an error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- chal  in  CHAL_W  challenge from switches (quasi-static)
- btn  in  1  raw re-evaluate button (asynchronous)
- clr_done  in  1  counter block acknowledges clear complete
- cnt_a  in  CNT_W  RO counter A value
- cnt_b  in  CNT_W  RO counter B value
- clr  out  1  counter clear request
- ro_en  out  1  oscillator/counter enable
- chal_q  out  CHAL_W  latched challenge driving the RO select mux
- resp  out  1  response bit (cnt_a > cnt_b)
- resp_valid  out  1  one-cycle pulse when resp is updated
- tie  out  1  set with resp_valid when cnt_a == cnt_b
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky clr_done timeout flag; cleared only by reset

Behaviour:
- Reset (async on rst_n low): state=IDLE; clr, ro_en, resp, resp_valid, tie, busy, err = 0; chal_q=0; last_chal=0; pending=0; init=0.

Input conditioning:
- btn passes through a 2-FF synchronizer; btn_rise = synced high AND previous synced low.
- First clock after reset with init=0: last_chal<=chal, init<=1, no trigger generated.

Triggering:
- trigger = init & ((chal != last_chal) | btn_rise).
- On trigger, last_chal<=chal in the same cycle.

State machine (one state per cycle minimum):
- IDLE: if trigger or pending → chal_q<=chal, pending<=0, clr<=1, go CLEAR.
- CLEAR: clr held high. When clr_done=1 sampled → clr<=0, go SETTLE. If CLR_TMO cycles elapse without clr_done → clr<=0, err<=1, go IDLE (no resp_valid).
- SETTLE: count SETTLE_CYC cycles with ro_en=0, then ro_en<=1, go RUN.
- RUN: ro_en high for exactly WINDOW_CYC cycles, then ro_en<=0, go COMPARE.
- COMPARE: wait one cycle after ro_en falls so counters freeze. Then resp<=(cnt_a>cnt_b) as an unsigned CNT_W compare; tie<=(cnt_a==cnt_b). On a tie, resp=0. Go DONE.
- DONE: resp_valid=1 for exactly this cycle, then go IDLE.

Timing and latency:
- Latency from trigger to resp_valid = 1 + clr_done wait + SETTLE_CYC + WINDOW_CYC + 2 cycles.

Boundary conditions:
- Trigger while busy sets pending=1; the in-flight evaluation completes using the old chal_q. Multiple triggers while busy collapse to one pending.
- clr_done already high on entry to CLEAR is accepted the next cycle.
- Simultaneous chal change and btn_rise count as one trigger.
- Counter values at full scale (all ones) compare correctly; no wrap handling is required since the window is bounded.
- resp and tie hold their values until the next COMPARE.
- rst_n asserted mid-RUN drops ro_en and clr asynchronously.

Optional Feature:
- Macro: PUF_RESP_ACCUM_EN.
- With the macro defined:
  - Adds outputs resp_word [7:0] and word_valid (1 bit).
  - Each resp_valid shifts resp into the LSB of resp_word.
  - After 8 responses, word_valid pulses for one cycle, aligned one cycle after the 8th resp_valid.
  - The bit counter wraps to 0; a btn_rise while IDLE also resets the bit counter.
  - Both outputs reset to 0.
- Without the macro: these ports and all related logic are absent.

Test Plan:
- Reset release with chal=8'h3C held static: no clr for 50 cycles; busy=0.
- chal 8'h3C→8'h5A, clr_done returned 3 cycles after clr, cnt_a=1200, cnt_b=1100: chal_q=8'h5A, ro_en high exactly 1000 cycles, then resp=1, tie=0, resp_valid pulse of exactly 1 cycle.
- btn press with chal unchanged, cnt_a=cnt_b=900: full sequence runs; resp=0, tie=1.
- clr_done never asserted: clr drops after 255 cycles; err=1 and stays 1; no resp_valid.
- chal changed twice during RUN: current evaluation finishes with the old chal_q; exactly one further evaluation starts from IDLE with the latest chal.
- PUF_RESP_ACCUM_EN defined, 8 evaluations with responses 1,0,1,1,0,0,1,0: resp_word=8'hB2 and a single word_valid pulse.

Source files
------------

// File: rtl/puf_eval_sequencer_if.sv
// -----------------------------------------------------------------------------
// puf_eval_sequencer_if
//
// Groups the signals between the PUF evaluation sequencer and the RO counter
// pair / challenge mux, together with the response outputs.
//
//   clr        sequencer -> counters  counter clear request
//   clr_done   counters  -> sequencer clear complete acknowledge
//   ro_en      sequencer -> counters  oscillator/counter enable
//   chal_q     sequencer -> mux       latched challenge (RO select)
//   cnt_a      counters  -> sequencer RO counter A value
//   cnt_b      counters  -> sequencer RO counter B value
//   resp       sequencer -> user      response bit (cnt_a > cnt_b)
//   resp_valid sequencer -> user      one-cycle pulse when resp is updated
//   tie        sequencer -> user      counts were equal in the last compare
//
// Modports: master = sequencer side, slave = counter/consumer side.
// -----------------------------------------------------------------------------
interface puf_eval_sequencer_if #(
    parameter int CHAL_W = 8,
    parameter int CNT_W  = 16
);
    logic              clr;
    logic              clr_done;
    logic              ro_en;
    logic [CHAL_W-1:0] chal_q;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic              resp;
    logic              resp_valid;
    logic              tie;

    modport master (
        output clr, ro_en, chal_q, resp, resp_valid, tie,
        input  clr_done, cnt_a, cnt_b
    );

    modport slave (
        input  clr, ro_en, chal_q, resp, resp_valid, tie,
        output clr_done, cnt_a, cnt_b
    );
endinterface

// File: rtl/puf_eval_sequencer.sv
// -----------------------------------------------------------------------------
// puf_eval_sequencer
//
// Sequences one ring-oscillator PUF evaluation per challenge: detects a new
// challenge or a button press, clears the RO counters through a clr/clr_done
// handshake, lets the oscillators settle, enables them for a fixed window,
// then compares the two counts and emits a response bit with a valid pulse.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   chal       in   challenge from switches (quasi-static)
//   btn        in   raw re-evaluate button (asynchronous)
//   bus        --   puf_eval_sequencer_if.master: clr, clr_done, ro_en,
//                   chal_q, cnt_a, cnt_b, resp, resp_valid, tie
//   busy       out  high in any state other than IDLE
//   err        out  sticky clr_done timeout flag, cleared only by reset
//
// Optional feature (macro PUF_RESP_ACCUM_EN):
//   resp_word  out  [7:0] shift register of the last responses (newest in LSB)
//   word_valid out  one-cycle pulse, one cycle after every 8th resp_valid
// -----------------------------------------------------------------------------
module puf_eval_sequencer #(
    parameter int CHAL_W     = 8,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int WINDOW_CYC = 1000,
    parameter int CLR_TMO    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHAL_W-1:0]   chal,
    input  logic                btn,
    puf_eval_sequencer_if.master bus,
    output logic                busy,
    output logic                err
`ifdef PUF_RESP_ACCUM_EN
    ,
    output logic [7:0]          resp_word,
    output logic                word_valid
`endif
);

    // One shared timer serves the clear timeout, settle and run windows, so
    // it must hold the largest of the three counts.
    localparam int TMR_MAX =
        (WINDOW_CYC > CLR_TMO)
            ? ((WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC)
            : ((CLR_TMO    > SETTLE_CYC) ? CLR_TMO    : SETTLE_CYC);
    localparam int TMR_W = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(CLR_TMO - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        COMPARE,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic               clr_r, clr_d;
    logic               ro_en_r, ro_en_d;
    logic [CHAL_W-1:0]  chal_q_r, chal_q_d;
    logic               resp_r, resp_d;
    logic               tie_r, tie_d;
    logic               resp_valid_r, resp_valid_d;
    logic               err_r, err_d;
    logic               pending, pending_d;

    logic [CNT_W-1:0]   cnt_a;
    logic [CNT_W-1:0]   cnt_b;

    // Input conditioning
    logic               btn_meta, btn_sync, btn_prev;
    logic               btn_rise;
    logic [CHAL_W-1:0]  last_chal;
    logic               init;
    logic               trigger;

    assign cnt_a = bus.cnt_a;
    assign cnt_b = bus.cnt_b;

    // -------------------------------------------------------------------------
    // Button synchronizer, edge detect and challenge-change detection.
    // The first clock after reset only captures the switches so that the
    // power-on challenge does not look like a change.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            btn_prev  <= 1'b0;
            last_chal <= '0;
            init      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge value of its neighbour, which is what makes this a
            // real two-stage synchronizer rather than a single wire.
            btn_meta <= btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            if (!init) begin
                last_chal <= chal;
                init      <= 1'b1;
            end else if (trigger) begin
                last_chal <= chal;
            end
        end
    end

    assign btn_rise = btn_sync & ~btn_prev;
    // A challenge change coinciding with a button edge is one trigger.
    assign trigger  = init & ((chal != last_chal) | btn_rise);

    // -------------------------------------------------------------------------
    // FSM state and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmr          <= '0;
            clr_r        <= 1'b0;
            ro_en_r      <= 1'b0;
            chal_q_r     <= '0;
            resp_r       <= 1'b0;
            tie_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            err_r        <= 1'b0;
            pending      <= 1'b0;
        end else begin
            state        <= state_d;
            tmr          <= tmr_d;
            clr_r        <= clr_d;
            ro_en_r      <= ro_en_d;
            chal_q_r     <= chal_q_d;
            resp_r       <= resp_d;
            tie_r        <= tie_d;
            resp_valid_r <= resp_valid_d;
            err_r        <= err_d;
            pending      <= pending_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state / next outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets its hold value first, so no
        // branch can leave one unassigned and infer a latch.
        state_d      = state;
        tmr_d        = tmr;
        clr_d        = clr_r;
        ro_en_d      = ro_en_r;
        chal_q_d     = chal_q_r;
        resp_d       = resp_r;
        tie_d        = tie_r;
        resp_valid_d = 1'b0;
        err_d        = err_r;
        // Triggers that arrive mid-evaluation collapse into one pending flag.
        pending_d    = pending | (trigger & (state != IDLE));

        unique case (state)
            IDLE: begin
                if (trigger || pending) begin
                    chal_q_d  = chal;
                    pending_d = 1'b0;
                    clr_d     = 1'b1;
                    tmr_d     = '0;
                    state_d   = CLEAR;
                end
            end

            CLEAR: begin
                if (bus.clr_done) begin
                    clr_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = SETTLE;
                end else if (tmr == TMO_LAST) begin
                    // Counter block never acknowledged: abandon this
                    // evaluation without producing a response.
                    clr_d   = 1'b0;
                    err_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end

            SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    ro_en_d = 1'b1;
                    tmr_d   = '0;
                    state_d = RUN;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end

            RUN: begin
                if (tmr == WINDOW_LAST) begin
                    ro_en_d = 1'b0;
                    tmr_d   = '0;
                    state_d = COMPARE;
                end else begin
                    tmr_d = tmr + TMR_W'(1);
                end
            end

            COMPARE: begin
                // ro_en dropped one cycle ago, so the counts are frozen.
                // A tie yields resp=0 because the compare is strict.
                resp_d       = (cnt_a > cnt_b);
                tie_d        = (cnt_a == cnt_b);
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.clr        = clr_r;
    assign bus.ro_en      = ro_en_r;
    assign bus.chal_q     = chal_q_r;
    assign bus.resp       = resp_r;
    assign bus.tie        = tie_r;
    assign bus.resp_valid = resp_valid_r;
    assign busy           = (state != IDLE);
    assign err            = err_r;

`ifdef PUF_RESP_ACCUM_EN
    // -------------------------------------------------------------------------
    // Response accumulator: packs eight consecutive responses into a byte.
    // -------------------------------------------------------------------------
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_word  <= '0;
            word_valid <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            word_valid <= 1'b0;
            if (resp_valid_r) begin
                resp_word  <= {resp_word[6:0], resp_r};
                bit_cnt    <= bit_cnt + 3'd1;
                word_valid <= (bit_cnt == 3'd7);
            end else if (btn_rise && (state == IDLE)) begin
                // Lets the user realign the byte boundary.
                bit_cnt <= '0;
            end
        end
    end
`endif

endmodule
